// File: rtl/nco_phase_acc.sv
// NCO phase accumulator: double-buffered tuning word, optional LFSR dither,
// static phase offset, truncation to the angle width with a 3-cycle valid strobe.
module nco_phase_acc #(
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned ANGLE_WIDTH = 20,
    parameter bit          DITHER      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [ACC_WIDTH-1:0]   freq_in,
    input  logic                   freq_load,
    output logic                   freq_ack,
    input  logic [ANGLE_WIDTH-1:0] phase_off,
    input  logic                   phase_sync,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic                   angle_valid
);

    localparam int unsigned FRAC_WIDTH = ACC_WIDTH - ANGLE_WIDTH;
    localparam int unsigned DW         = (FRAC_WIDTH < 16) ? FRAC_WIDTH : 16;

    logic [ACC_WIDTH-1:0]   shadow_word;
    logic [ACC_WIDTH-1:0]   active_word;
    logic                   load_pending;
    logic                   apply_c;

    logic [ACC_WIDTH-1:0]   acc;
    logic                   en_d1;
    logic [ANGLE_WIDTH-1:0] off_d1;

    logic [ANGLE_WIDTH-1:0] sum_hi;
    logic                   en_d2;
    logic [ANGLE_WIDTH-1:0] off_d2;

    logic [ACC_WIDTH-1:0]   dither_c;
    logic [ANGLE_WIDTH-1:0] sum_hi_c;

    assign apply_c  = enable & load_pending;
    assign sum_hi_c = ANGLE_WIDTH'((acc + dither_c) >> FRAC_WIDTH);

    // Tuning word double buffer; a load in the apply cycle keeps pending set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_word  <= '0;
            active_word  <= '0;
            load_pending <= 1'b0;
            freq_ack     <= 1'b0;
        end else begin
            if (freq_load) begin
                shadow_word <= freq_in;
            end
            if (apply_c) begin
                active_word <= shadow_word;
            end
            if (freq_load) begin
                load_pending <= 1'b1;
            end else if (apply_c) begin
                load_pending <= 1'b0;
            end
            freq_ack <= apply_c;
        end
    end

    // Stage 1: phase integration, sync has priority over accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            en_d1  <= 1'b0;
            off_d1 <= '0;
        end else begin
            if (phase_sync) begin
                acc <= '0;
            end else if (enable) begin
                acc <= acc + active_word;
            end
            en_d1 <= enable;
            if (enable) begin
                off_d1 <= phase_off;
            end
        end
    end

    generate
        if (DITHER) begin : g_dither
            logic [15:0] lfsr;

            // x^16+x^14+x^13+x^11+1 Fibonacci, one step per sample
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lfsr <= 16'hACE1;
                end else if (en_d1) begin
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                end
            end

            assign dither_c = ACC_WIDTH'(lfsr[DW-1:0]);
        end else begin : g_no_dither
            assign dither_c = '0;
        end
    endgenerate

    // Stage 2: dither below the truncation point, keep only the angle bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_hi <= '0;
            en_d2  <= 1'b0;
            off_d2 <= '0;
        end else begin
            en_d2 <= en_d1;
            if (en_d1) begin
                sum_hi <= sum_hi_c;
                off_d2 <= off_d1;
            end
        end
    end

    // Stage 3: offset add, angle holds between samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle       <= '0;
            angle_valid <= 1'b0;
        end else begin
            angle_valid <= en_d2;
            if (en_d2) begin
                angle <= sum_hi + off_d2;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed bench for nco_phase_acc: one undithered and one dithered instance
// driven from the same stimulus.
module tb_nco_phase_acc;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] freq_in;
    logic        freq_load;
    logic [19:0] phase_off;
    logic        phase_sync;

    logic        ack0, ack1;
    logic [19:0] angle0, angle1;
    logic        valid0, valid1;

    int n_checks = 0;
    int n_pass   = 0;

    nco_phase_acc #(.ACC_WIDTH(32), .ANGLE_WIDTH(20), .DITHER(1'b0)) u_nodither (
        .clk(clk), .rst_n(rst_n), .enable(enable), .freq_in(freq_in),
        .freq_load(freq_load), .freq_ack(ack0), .phase_off(phase_off),
        .phase_sync(phase_sync), .angle(angle0), .angle_valid(valid0)
    );

    nco_phase_acc #(.ACC_WIDTH(32), .ANGLE_WIDTH(20), .DITHER(1'b1)) u_dither (
        .clk(clk), .rst_n(rst_n), .enable(enable), .freq_in(freq_in),
        .freq_load(freq_load), .freq_ack(ack1), .phase_off(phase_off),
        .phase_sync(phase_sync), .angle(angle1), .angle_valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] prev;
    logic [19:0] diff;
    logic        found;
    logic        ack_seen;
    logic        bad_flag;
    int          acks;
    int          bad;
    int          bad0;
    int          nv;
    logic [19:0] exp_d [5];
    logic [8:0]  en_pat;
    logic [8:0]  vhist;
    logic [19:0] ahist [9];
    logic [31:0] m_acc;
    logic [15:0] m_lfsr;
    logic [31:0] t;

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        freq_in    = '0;
        freq_load  = 1'b0;
        phase_off  = '0;
        phase_sync = 1'b0;

        // Reset defaults and first-sample latency
        repeat (5) tick();
        check("rst_angle0", 32'(angle0), 32'h0);
        check("rst_valid0", 32'(valid0), 32'h0);
        check("rst_ack0",   32'(ack0),   32'h0);
        check("rst_angle1", 32'(angle1), 32'h0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        check("lat_valid_c2", 32'(valid0), 32'h0);
        tick();
        check("lat_valid_c3", 32'(valid0), 32'h1);
        ack_seen = 1'b0;
        bad_flag = 1'b0;
        repeat (20) begin
            tick();
            ack_seen = ack_seen | ack0 | ack1;
            if (angle0 != 20'h0 || angle1 != 20'h0 || !valid0) bad_flag = 1'b1;
        end
        check("idle_ack",   32'(ack_seen), 32'h0);
        check("idle_angle", 32'(bad_flag), 32'h0);

        // Tuning word load and ack timing
        freq_in   = 32'h0010_0000;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
        check("ack_early", 32'(ack0), 32'h0);
        tick();
        check("ack_pulse", 32'(ack0), 32'h1);
        tick();
        check("ack_clear", 32'(ack0), 32'h0);
        repeat (4) tick();
        prev = angle0;
        tick();
        diff = angle0 - prev;
        check("step_100a", 32'(diff), 32'h100);
        prev = angle0;
        tick();
        diff = angle0 - prev;
        check("step_100b", 32'(diff), 32'h100);

        // Wrap from FFF00 to 00000 and full 4096-step period
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (angle0 == 20'hFFF00) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wrap_found", 32'(found), 32'h1);
        tick();
        check("wrap_zero", 32'(angle0), 32'h0);
        repeat (4096) tick();
        check("wrap_period", 32'(angle0), 32'h0);

        // Load while running: apply step still uses the old word
        freq_in   = 32'h0020_0000;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
        prev = angle0;
        exp_d = '{20'h100, 20'h100, 20'h100, 20'h200, 20'h200};
        for (int k = 0; k < 5; k++) begin
            tick();
            diff = angle0 - prev;
            check($sformatf("load_step%0d", k), 32'(diff), 32'(exp_d[k]));
            prev = angle0;
        end

        // Back-to-back loads while idle: one ack, last value wins
        enable = 1'b0;
        repeat (3) tick();
        freq_in   = 32'h0030_0000;
        freq_load = 1'b1;
        tick();
        freq_in   = 32'h0004_0000;
        tick();
        freq_load = 1'b0;
        enable    = 1'b1;
        acks = 0;
        repeat (8) begin
            tick();
            acks += int'(ack0);
        end
        check("b2b_acks", 32'(acks), 32'h1);
        prev = angle0;
        tick();
        diff = angle0 - prev;
        check("b2b_step", 32'(diff), 32'h40);

        // Phase sync with offset
        phase_off = 20'h40000;
        repeat (4) tick();
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        tick();
        tick();
        check("sync_angle0", 32'(angle0), 32'h40000);
        tick();
        check("sync_angle1", 32'(angle0), 32'h40040);
        tick();
        check("sync_angle2", 32'(angle0), 32'h40080);

        // Gated enable 1,0,0,1
        enable = 1'b0;
        repeat (4) tick();
        check("gate_idle", 32'(valid0), 32'h0);
        en_pat = 9'b0_0000_1001;
        for (int i = 0; i < 9; i++) begin
            enable = en_pat[i];
            tick();
            vhist[i] = valid0;
            ahist[i] = angle0;
        end
        enable = 1'b0;
        check("gate_valid", 32'(vhist), 32'h024);
        check("gate_hold3", 32'(ahist[3]), 32'(ahist[2]));
        check("gate_hold4", 32'(ahist[4]), 32'(ahist[2]));
        diff = ahist[5] - ahist[2];
        check("gate_step", 32'(diff), 32'h40);

        // Dither with zero frequency never reaches the angle LSB
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        phase_off = '0;
        enable    = 1'b1;
        bad = 0;
        nv  = 0;
        repeat (2000) begin
            tick();
            if (valid1) begin
                nv++;
                if (angle1 != 20'h0) bad++;
            end
        end
        check("dither_zero", 32'(bad), 32'h0);
        check("dither_nsamples", 32'(nv), 32'd1998);

        // Dithered stream against a reference LFSR seeded at ACE1
        enable = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n     = 1'b1;
        freq_in   = 32'h0000_1235;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
        enable    = 1'b1;
        m_acc  = 32'h0;
        m_lfsr = 16'hACE1;
        bad  = 0;
        bad0 = 0;
        nv   = 0;
        repeat (1500) begin
            tick();
            if (valid1) begin
                nv++;
                t = m_acc + {20'h0, m_lfsr[11:0]};
                if (angle1 !== t[31:12]) bad++;
                if (angle0 !== m_acc[31:12]) bad0++;
                m_acc  = m_acc + 32'h0000_1235;
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
        end
        check("dither_stream", 32'(bad), 32'h0);
        check("nodither_stream", 32'(bad0), 32'h0);
        check("stream_samples", 32'(nv), 32'd1498);

        // Asynchronous reset mid-stream clears outputs immediately
        rst_n = 1'b0;
        #1;
        check("async_rst_angle1", 32'(angle1), 32'h0);
        check("async_rst_valid1", 32'(valid1), 32'h0);
        check("async_rst_angle0", 32'(angle0), 32'h0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
